// File: rtl/rom_rr_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// rom_rr_arbiter_pkg : shared widths and FSM encoding for ROM-client blocks
// Rev 1.0
// ============================================================================
package rom_rr_arbiter_pkg;

  localparam int AW_DEF = 12;
  localparam int DW_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/rom_rr_arbiter_if.sv
`default_nettype none
// ============================================================================
// rom_rr_arbiter_if : client handshakes plus ROM address/data bus
// Rev 1.0
// ============================================================================
interface rom_rr_arbiter_if #(
  parameter int AW = rom_rr_arbiter_pkg::AW_DEF,
  parameter int DW = rom_rr_arbiter_pkg::DW_DEF
);
  logic          req0;
  logic          req1;
  logic [AW-1:0] addr0;
  logic [AW-1:0] addr1;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_data;
  logic          gnt0;
  logic          gnt1;
  logic          vld0;
  logic          vld1;
  logic [DW-1:0] rdata;
  logic          busy;

  // master = arbiter side; slave = requesters together with the ROM
  modport master (
    input  req0, req1, addr0, addr1, rom_data,
    output rom_addr, gnt0, gnt1, vld0, vld1, rdata, busy
  );

  modport slave (
    output req0, req1, addr0, addr1, rom_data,
    input  rom_addr, gnt0, gnt1, vld0, vld1, rdata, busy
  );
endinterface
`default_nettype wire

// File: rtl/rom_rr_arbiter_rr_pick2.sv
`default_nettype none
// ============================================================================
// rom_rr_arbiter_rr_pick2 : combinational two-way round-robin pick
// Rev 1.0
// ============================================================================
module rom_rr_arbiter_rr_pick2 (
  input  logic req0_i,
  input  logic req1_i,
  input  logic last_i,
  output logic any_o,
  output logic win_o
);

  // A lone requester always wins; a tie goes to whoever was not served last.
  assign any_o = req0_i | req1_i;
  assign win_o = (req0_i & req1_i) ? ~last_i : req1_i;

endmodule
`default_nettype wire

// File: rtl/rom_rr_arbiter.sv
`default_nettype none
// ============================================================================
// rom_rr_arbiter : shares one combinational ROM between two req/vld clients
// Rev 1.0
// ============================================================================
module rom_rr_arbiter
  import rom_rr_arbiter_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic             clk,
  input  logic             reset,
  rom_rr_arbiter_if.master bus
);

  state_e        state_q, state_d;
  logic [AW-1:0] rom_addr_q, rom_addr_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          gnt0_q, gnt0_d;
  logic          gnt1_q, gnt1_d;
  logic          vld0_q, vld0_d;
  logic          vld1_q, vld1_d;
  logic          busy_q, busy_d;
  logic          last_q, last_d;
  logic          owner_q, owner_d;
  logic          pick_any;
  logic          pick_win;

  rom_rr_arbiter_rr_pick2 u_pick (
    .req0_i (bus.req0),
    .req1_i (bus.req1),
    .last_i (last_q),
    .any_o  (pick_any),
    .win_o  (pick_win)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      rom_addr_q <= '0;
      rdata_q    <= '0;
      gnt0_q     <= 1'b0;
      gnt1_q     <= 1'b0;
      vld0_q     <= 1'b0;
      vld1_q     <= 1'b0;
      busy_q     <= 1'b0;
      last_q     <= 1'b1;
      owner_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      rom_addr_q <= rom_addr_d;
      rdata_q    <= rdata_d;
      gnt0_q     <= gnt0_d;
      gnt1_q     <= gnt1_d;
      vld0_q     <= vld0_d;
      vld1_q     <= vld1_d;
      busy_q     <= busy_d;
      last_q     <= last_d;
      owner_q    <= owner_d;
    end
  end

  // Grants and valids default low so each one is a single-cycle pulse.
  always_comb begin
    state_d    = state_q;
    rom_addr_d = rom_addr_q;
    rdata_d    = rdata_q;
    gnt0_d     = 1'b0;
    gnt1_d     = 1'b0;
    vld0_d     = 1'b0;
    vld1_d     = 1'b0;
    last_d     = last_q;
    owner_d    = owner_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          state_d    = ST_READ;
          owner_d    = pick_win;
          rom_addr_d = pick_win ? bus.addr1 : bus.addr0;
          gnt0_d     = ~pick_win;
          gnt1_d     = pick_win;
        end
      end
      ST_READ: begin
        rdata_d = bus.rom_data;
        vld0_d  = ~owner_q;
        vld1_d  = owner_q;
        last_d  = owner_q;
        state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  assign bus.rom_addr = rom_addr_q;
  assign bus.rdata    = rdata_q;
  assign bus.gnt0     = gnt0_q;
  assign bus.gnt1     = gnt1_q;
  assign bus.vld0     = vld0_q;
  assign bus.vld1     = vld1_q;
  assign bus.busy     = busy_q;

endmodule
`default_nettype wire
